// File: rtl/tlbx_if.sv
// Bus bundle for the TLB: two search ports, write/read ports, invalidate walk
// control and the random-replacement index pair.
interface tlbx_if #(
  parameter int TLBNUM = 16,
  parameter int ASIDW  = 8
);
  localparam int IDXW = $clog2(TLBNUM);

  logic [18:0]      s0_vpn2;
  logic             s0_odd_page;
  logic [ASIDW-1:0] s0_asid;
  logic             s0_found;
  logic [IDXW-1:0]  s0_index;
  logic [19:0]      s0_pfn;
  logic [2:0]       s0_c;
  logic             s0_d;
  logic             s0_v;

  logic [18:0]      s1_vpn2;
  logic             s1_odd_page;
  logic [ASIDW-1:0] s1_asid;
  logic             s1_found;
  logic [IDXW-1:0]  s1_index;
  logic [19:0]      s1_pfn;
  logic [2:0]       s1_c;
  logic             s1_d;
  logic             s1_v;

  logic             we;
  logic [IDXW-1:0]  w_index;
  logic [18:0]      w_vpn2;
  logic [ASIDW-1:0] w_asid;
  logic             w_g;
  logic [19:0]      w_pfn0, w_pfn1;
  logic [2:0]       w_c0, w_c1;
  logic             w_d0, w_d1, w_v0, w_v1;

  logic [IDXW-1:0]  r_index;
  logic             r_e;
  logic [18:0]      r_vpn2;
  logic [ASIDW-1:0] r_asid;
  logic             r_g;
  logic [19:0]      r_pfn0, r_pfn1;
  logic [2:0]       r_c0, r_c1;
  logic             r_d0, r_d1, r_v0, r_v1;

  logic             inv_req;
  logic [1:0]       inv_op;
  logic [ASIDW-1:0] inv_asid;
  logic             inv_busy;
  logic             inv_done;

  logic             wired_we;
  logic [IDXW-1:0]  w_wired;
  logic [IDXW-1:0]  wired;
  logic [IDXW-1:0]  rand_index;

  modport slave (
    input  s0_vpn2, s0_odd_page, s0_asid,
    output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    input  s1_vpn2, s1_odd_page, s1_asid,
    output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    input  we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_pfn1,
           w_c0, w_c1, w_d0, w_d1, w_v0, w_v1,
    input  r_index,
    output r_e, r_vpn2, r_asid, r_g, r_pfn0, r_pfn1,
           r_c0, r_c1, r_d0, r_d1, r_v0, r_v1,
    input  inv_req, inv_op, inv_asid,
    output inv_busy, inv_done,
    input  wired_we, w_wired,
    output wired, rand_index
  );

  modport master (
    output s0_vpn2, s0_odd_page, s0_asid,
    input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    output s1_vpn2, s1_odd_page, s1_asid,
    input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    output we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_pfn1,
           w_c0, w_c1, w_d0, w_d1, w_v0, w_v1,
    output r_index,
    input  r_e, r_vpn2, r_asid, r_g, r_pfn0, r_pfn1,
           r_c0, r_c1, r_d0, r_d1, r_v0, r_v1,
    output inv_req, inv_op, inv_asid,
    input  inv_busy, inv_done,
    output wired_we, w_wired,
    input  wired, rand_index
  );
endinterface

// File: rtl/tlbx.sv
// Fully associative MIPS-style TLB: dual combinational lookup, one write port,
// a serial invalidate walker and a wired/random replacement index generator.
module tlbx #(
  parameter int TLBNUM = 16,
  parameter int ASIDW  = 8
) (
  input logic   clk,
  input logic   resetn,
  tlbx_if.slave bus
);
  localparam int IDXW = $clog2(TLBNUM);
  localparam logic [IDXW-1:0] LAST = IDXW'(TLBNUM - 1);

  typedef enum logic [1:0] {IDLE, WALK, DONE} inv_state_t;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] idx;
    logic [19:0]     pfn;
    logic [2:0]      c;
    logic            d;
    logic            v;
  } srch_t;

  // Entry storage; only the existence bits are reset.
  logic [TLBNUM-1:0] r_e;
  logic [18:0]       r_vpn2 [TLBNUM];
  logic [ASIDW-1:0]  r_asid [TLBNUM];
  logic              r_g    [TLBNUM];
  logic [19:0]       r_pfn0 [TLBNUM];
  logic [19:0]       r_pfn1 [TLBNUM];
  logic [2:0]        r_c0   [TLBNUM];
  logic [2:0]        r_c1   [TLBNUM];
  logic              r_d0   [TLBNUM];
  logic              r_d1   [TLBNUM];
  logic              r_v0   [TLBNUM];
  logic              r_v1   [TLBNUM];

  inv_state_t        r_state, w_state_nxt;
  logic [IDXW-1:0]   r_cnt;
  logic [1:0]        r_op;
  logic [ASIDW-1:0]  r_inv_asid;
  logic [IDXW-1:0]   r_wired;
  logic [IDXW-1:0]   r_rand;

  logic              w_clr;
  logic              w_busy;
  logic              w_done;
  srch_t             w_s0, w_s1;

  // Scanning from the top down lets the lowest matching index win.
  function automatic srch_t lookup(input logic [18:0]      vpn2,
                                   input logic             odd,
                                   input logic [ASIDW-1:0] asid);
    srch_t res;
    res = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (r_e[i] && (r_vpn2[i] == vpn2) && ((r_asid[i] == asid) || r_g[i])) begin
        res.found = 1'b1;
        res.idx   = IDXW'(i);
        res.pfn   = odd ? r_pfn1[i] : r_pfn0[i];
        res.c     = odd ? r_c1[i]   : r_c0[i];
        res.d     = odd ? r_d1[i]   : r_d0[i];
        res.v     = odd ? r_v1[i]   : r_v0[i];
      end
    end
    return res;
  endfunction

  always_comb begin
    w_s0 = lookup(bus.s0_vpn2, bus.s0_odd_page, bus.s0_asid);
    w_s1 = lookup(bus.s1_vpn2, bus.s1_odd_page, bus.s1_asid);
  end

  assign bus.s0_found = w_s0.found;
  assign bus.s0_index = w_s0.idx;
  assign bus.s0_pfn   = w_s0.pfn;
  assign bus.s0_c     = w_s0.c;
  assign bus.s0_d     = w_s0.d;
  assign bus.s0_v     = w_s0.v;
  assign bus.s1_found = w_s1.found;
  assign bus.s1_index = w_s1.idx;
  assign bus.s1_pfn   = w_s1.pfn;
  assign bus.s1_c     = w_s1.c;
  assign bus.s1_d     = w_s1.d;
  assign bus.s1_v     = w_s1.v;

  assign bus.r_e    = r_e[bus.r_index];
  assign bus.r_vpn2 = r_vpn2[bus.r_index];
  assign bus.r_asid = r_asid[bus.r_index];
  assign bus.r_g    = r_g[bus.r_index];
  assign bus.r_pfn0 = r_pfn0[bus.r_index];
  assign bus.r_pfn1 = r_pfn1[bus.r_index];
  assign bus.r_c0   = r_c0[bus.r_index];
  assign bus.r_c1   = r_c1[bus.r_index];
  assign bus.r_d0   = r_d0[bus.r_index];
  assign bus.r_d1   = r_d1[bus.r_index];
  assign bus.r_v0   = r_v0[bus.r_index];
  assign bus.r_v1   = r_v1[bus.r_index];

  always_ff @(posedge clk) begin
    if (bus.we) begin
      r_vpn2[bus.w_index] <= bus.w_vpn2;
      r_asid[bus.w_index] <= bus.w_asid;
      r_g[bus.w_index]    <= bus.w_g;
      r_pfn0[bus.w_index] <= bus.w_pfn0;
      r_pfn1[bus.w_index] <= bus.w_pfn1;
      r_c0[bus.w_index]   <= bus.w_c0;
      r_c1[bus.w_index]   <= bus.w_c1;
      r_d0[bus.w_index]   <= bus.w_d0;
      r_d1[bus.w_index]   <= bus.w_d1;
      r_v0[bus.w_index]   <= bus.w_v0;
      r_v1[bus.w_index]   <= bus.w_v1;
    end
  end

  // The write is ordered after the walk clear so a colliding write keeps e=1.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_e <= '0;
    end else begin
      if (w_clr)  r_e[r_cnt]       <= 1'b0;
      if (bus.we) r_e[bus.w_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && bus.inv_req) r_cnt <= '0;
      else if (r_state == WALK)           r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && bus.inv_req) begin
      r_op       <= bus.inv_op;
      r_inv_asid <= bus.inv_asid;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (bus.inv_req) w_state_nxt = WALK;
      WALK: begin
        w_busy = 1'b1;
        case (r_op)
          2'd0:    w_clr = 1'b1;
          2'd1:    w_clr = !r_g[r_cnt] && (r_asid[r_cnt] == r_inv_asid);
          2'd2:    w_clr = r_g[r_cnt];
          default: w_clr = 1'b0;
        endcase
        if (r_cnt == LAST) w_state_nxt = DONE;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.inv_busy = w_busy;
  assign bus.inv_done = w_done;

  // Random index counts down through the non-wired region and wraps to the top.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wired <= '0;
      r_rand  <= LAST;
    end else if (bus.wired_we) begin
      r_wired <= bus.w_wired;
      r_rand  <= LAST;
    end else if (r_rand <= r_wired) begin
      r_rand  <= LAST;
    end else begin
      r_rand  <= r_rand - 1'b1;
    end
  end

  assign bus.wired      = r_wired;
  assign bus.rand_index = r_rand;
endmodule

// File: doc/tlbx.md
TLBX -- requirements
Module: tlbx

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of entries (power of two, 4..64); IDXW = log2(TLBNUM) derived.
REQ-002 SHALL have parameter ASIDW, default 8, ASID width.
REQ-003 SHALL have ports: clk  in  1  clock; resetn  in  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have, for K=0,1, search ports: sK_vpn2 in 19; sK_odd_page in 1; sK_asid in ASIDW; sK_found out 1; sK_index out IDXW; sK_pfn out 20; sK_c out 3; sK_d out 1; sK_v out 1.
REQ-005 SHALL have write port: we in 1; w_index in IDXW; w_vpn2 in 19; w_asid in ASIDW; w_g in 1; w_pfn0/w_pfn1 in 20; w_c0/w_c1 in 3; w_d0/w_d1/w_v0/w_v1 in 1.
REQ-006 SHALL have read port: r_index in IDXW; r_e out 1 (entry valid); r_vpn2, r_asid, r_g, r_pfn0/1, r_c0/1, r_d0/1, r_v0/1 out, widths as write port.
REQ-007 SHALL have invalidate port: inv_req in 1; inv_op in 2; inv_asid in ASIDW; inv_busy out 1; inv_done out 1.
REQ-008 SHALL have replacement port: wired_we in 1; w_wired in IDXW; wired out IDXW; rand_index out IDXW.

Function
REQ-009 SHALL keep a per-entry existence bit e; entry fields other than e are not reset.
REQ-010 SHALL match entry i for port K when e[i] & vpn2 equal & (asid equal | g[i]); combinational, same-cycle.
REQ-011 SHALL, on multiple matches, select the lowest matching index.
REQ-012 SHALL, when sK_found=0, drive sK_index, sK_pfn, sK_c, sK_d, sK_v to 0.
REQ-013 SHALL select odd-half fields (pfn1,c1,d1,v1) when sK_odd_page=1, else even-half fields.
REQ-014 SHALL, on posedge with we=1, write all fields of entry w_index and set e=1; visible to search/read from the next cycle.
REQ-015 SHALL drive read outputs combinationally from entry r_index, including r_e.
REQ-016 SHALL implement invalidate FSM states IDLE, WALK, DONE; reset state IDLE.
REQ-017 SHALL, in IDLE with inv_req=1, latch inv_op/inv_asid, clear walk counter to 0, enter WALK; inv_req outside IDLE SHALL be ignored.
REQ-018 SHALL, in WALK, examine one entry per cycle at counter index, clear its e if criterion holds, increment counter; after index TLBNUM-1 enter DONE.
REQ-019 SHALL use criteria: op0 all entries; op1 g=0 and asid==inv_asid; op2 g=1 only; op3 none (walk still runs).
REQ-020 SHALL assert inv_busy in WALK and DONE, inv_done only in DONE (one-cycle pulse), then return to IDLE; req at edge t gives inv_done high during cycle t+TLBNUM+1.
REQ-021 SHALL, when we targets the entry the walk clears in the same cycle, let the write win (e=1 after).
REQ-022 SHALL let searches during WALK see current e values (entries not yet walked still match).
REQ-023 SHALL decrement rand_index each cycle; when rand_index <= wired, next value is TLBNUM-1.
REQ-024 SHALL, on wired_we=1, load wired <= w_wired and rand_index <= TLBNUM-1 next cycle; if wired = TLBNUM-1, rand_index holds TLBNUM-1.

Reset
REQ-025 SHALL, when resetn=0 at posedge, clear all e, FSM to IDLE, walk counter 0, wired 0, rand_index TLBNUM-1; reset mid-walk aborts with no inv_done.
REQ-026 SHALL, out of reset, drive sK_found=0, sK_index/pfn/c/d/v=0, inv_busy=0, inv_done=0, r_e=0.

Verification
REQ-027 Reset then search vpn2=0x5fe00 asid=0 -> s0_found=0, s0_index=0, s0_pfn=0; rand_index=15.
REQ-028 Write idx3 {vpn2=0x00012, asid=5, g=0, pfn0=0x111, pfn1=0x222, v0=v1=1} -> next cycle s0(0x00012, odd=1, asid=5) gives found=1, index=3, pfn=0x222; asid=6 gives found=0.
REQ-029 Same vpn2 written g=1 at idx2 and idx7 -> search any asid returns index=2.
REQ-030 Entries idx1 {asid=5,g=0}, idx4 {asid=5,g=1}, idx9 {asid=6,g=0}; inv_req op1 asid=5 at t -> inv_busy cycles t+1..t+17, inv_done at t+17 only; afterwards only idx1 has e=0; second inv_req at t+5 ignored.
REQ-031 During op0 walk, we to idx10 in the cycle the walk reaches idx10 -> r_e(10)=1 after done; all others 0.
REQ-032 wired_we w_wired=12 -> rand_index sequence 15,14,13,12,15,14...; w_wired=15 -> rand_index constant 15.
